privilege_guard: RTL and testbench

- Synthesizable privilege monitor that sits directly beside CPUTop and drives its io_programMemoryOffset and io_dataMemoryOffset inputs.
- Watches CPUTop's PC, jump, data-memory and register-file activity.
- Selects the ring-0 or user address offsets and latches the first protection violation.
- Asserts a halt/done indication on CPU completion, on a fault, or on a watchdog timeout.
- Moves the privilege checks currently done in simulation into RTL so they can run on hardware.

---
 rtl/privilege_guard.sv | 167 ++++++++++++++++
 tb/tb_privilege_guard.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/privilege_guard.sv
// Privilege monitor beside CPUTop: selects ring-0/user memory offsets, latches the
// first protection violation and raises halt on fault, CPU completion or watchdog.
module privilege_guard #(
  parameter int ADDR_W        = 16,
  parameter int RING0_PC_END  = 255,
  parameter int RING0_ENTRY   = 0,
  parameter int RING0_MEM_END = 15,
  parameter int RING0_REGS    = 3,
  parameter int STEP_MAX      = 100000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_run,
  input  logic [ADDR_W-1:0] io_pc,
  input  logic              io_jump,
  input  logic [ADDR_W-1:0] io_jumpTarget,
  input  logic              io_dataAccess,
  input  logic [ADDR_W-1:0] io_dataAddr,
  input  logic              io_regRead,
  input  logic [4:0]        io_regASel,
  input  logic [4:0]        io_regBSel,
  input  logic              io_regWriteEnable,
  input  logic [4:0]        io_regWriteSel,
  input  logic [31:0]       io_syscallReg,
  input  logic              io_cpuDone,
  output logic [ADDR_W-1:0] io_programMemoryOffset,
  output logic [ADDR_W-1:0] io_dataMemoryOffset,
  output logic              io_privileged,
  output logic              io_fault,
  output logic [2:0]        io_faultCause,
  output logic [ADDR_W-1:0] io_faultPc,
  output logic              io_halt,
  output logic [31:0]       io_cycleCount
);

  // state  | meaning
  // IDLE   | waiting for io_run
  // RUN    | CPU executing, user-mode accesses checked every edge
  // FAULT  | first violation latched, CPU halted until reset
  // DONE   | CPU finished cleanly, halted until reset

  localparam logic [ADDR_W-1:0] PC_END      = ADDR_W'(RING0_PC_END);
  localparam logic [ADDR_W-1:0] ENTRY_PC    = ADDR_W'(RING0_ENTRY);
  localparam logic [ADDR_W-1:0] MEM_END     = ADDR_W'(RING0_MEM_END);
  localparam logic [4:0]        REGS_END    = 5'(RING0_REGS);
  localparam logic [ADDR_W-1:0] USER_OFFSET = ADDR_W'(RING0_PC_END + 1);
  localparam logic [31:0]       WD_LIMIT    = 32'(STEP_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        cause_nxt;
  logic [2:0]        cause_q;
  logic [ADDR_W-1:0] fault_pc_q;
  logic [31:0]       cycle_cnt;
  logic              user_mode;
  logic              checking;
  logic              viol_jump;
  logic              viol_mem;
  logic              viol_rega;
  logic              viol_regb;
  logic              viol_regw;
  logic              viol_wdog;

  assign io_privileged = (io_pc <= PC_END);
  assign user_mode     = ~io_privileged;
  assign checking      = (state == S_RUN) && user_mode;

  // Offsets are forced to zero while reset is held so every output reads 0 in reset.
  assign io_programMemoryOffset =
    (!reset || io_privileged || (io_syscallReg != 32'd0)) ? '0 : USER_OFFSET;
  assign io_dataMemoryOffset =
    (!reset || io_privileged) ? '0 : USER_OFFSET;

  always_comb begin
    viol_jump = io_jump && (io_jumpTarget <= PC_END) && (io_jumpTarget != ENTRY_PC);
    viol_mem  = io_dataAccess && (io_dataAddr <= MEM_END);
    viol_rega = io_regRead && (io_regASel <= REGS_END);
    viol_regb = io_regRead && (io_regBSel <= REGS_END);
    viol_regw = io_regWriteEnable && (io_regWriteSel <= REGS_END);
    // >= rather than == so a limit crossed while privileged still fires on return to user mode
    viol_wdog = (cycle_cnt >= WD_LIMIT);
  end

  always_comb begin
    cause_nxt = 3'd0;
    if (checking) begin
      if (viol_jump)      cause_nxt = 3'd1;
      else if (viol_mem)  cause_nxt = 3'd2;
      else if (viol_rega) cause_nxt = 3'd3;
      else if (viol_regb) cause_nxt = 3'd4;
      else if (viol_regw) cause_nxt = 3'd5;
      else if (viol_wdog) cause_nxt = 3'd6;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (io_run) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (cause_nxt != 3'd0) state_nxt = S_FAULT;
        else if (io_cpuDone)   state_nxt = S_DONE;
      end
      S_FAULT: state_nxt = S_FAULT;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    io_fault = 1'b0;
    io_halt  = 1'b0;
    case (state)
      S_FAULT: begin
        io_fault = 1'b1;
        io_halt  = 1'b1;
      end
      S_DONE: begin
        io_halt = 1'b1;
      end
      default: begin
        io_fault = 1'b0;
        io_halt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= 32'd0;
    end else if ((state == S_RUN) && (cycle_cnt != 32'hFFFF_FFFF)) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cause_q    <= 3'd0;
      fault_pc_q <= '0;
    end else if ((state == S_RUN) && (cause_nxt != 3'd0)) begin
      cause_q    <= cause_nxt;
      fault_pc_q <= io_pc;
    end
  end

  assign io_faultCause = cause_q;
  assign io_faultPc    = fault_pc_q;
  assign io_cycleCount = cycle_cnt;

endmodule

// File: tb/tb_privilege_guard.sv
// Randomized and directed bench for privilege_guard against a behavioural model.
module tb_privilege_guard;

  localparam int TB_STEP = 20;

  logic        clock;
  logic        reset;
  logic        io_run;
  logic [15:0] io_pc;
  logic        io_jump;
  logic [15:0] io_jumpTarget;
  logic        io_dataAccess;
  logic [15:0] io_dataAddr;
  logic        io_regRead;
  logic [4:0]  io_regASel;
  logic [4:0]  io_regBSel;
  logic        io_regWriteEnable;
  logic [4:0]  io_regWriteSel;
  logic [31:0] io_syscallReg;
  logic        io_cpuDone;
  logic [15:0] io_programMemoryOffset;
  logic [15:0] io_dataMemoryOffset;
  logic        io_privileged;
  logic        io_fault;
  logic [2:0]  io_faultCause;
  logic [15:0] io_faultPc;
  logic        io_halt;
  logic [31:0] io_cycleCount;

  int n_cmp = 0;
  int n_bad = 0;

  // behavioural model
  bit          m_started;
  bit          m_fault;
  bit          m_done;
  logic [31:0] m_count;
  logic [2:0]  m_cause;
  logic [15:0] m_fpc;

  privilege_guard #(.STEP_MAX(TB_STEP)) dut (
    .clock(clock), .reset(reset), .io_run(io_run), .io_pc(io_pc),
    .io_jump(io_jump), .io_jumpTarget(io_jumpTarget),
    .io_dataAccess(io_dataAccess), .io_dataAddr(io_dataAddr),
    .io_regRead(io_regRead), .io_regASel(io_regASel), .io_regBSel(io_regBSel),
    .io_regWriteEnable(io_regWriteEnable), .io_regWriteSel(io_regWriteSel),
    .io_syscallReg(io_syscallReg), .io_cpuDone(io_cpuDone),
    .io_programMemoryOffset(io_programMemoryOffset),
    .io_dataMemoryOffset(io_dataMemoryOffset), .io_privileged(io_privileged),
    .io_fault(io_fault), .io_faultCause(io_faultCause), .io_faultPc(io_faultPc),
    .io_halt(io_halt), .io_cycleCount(io_cycleCount)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int first_cause();
    bit hit [6];
    hit[0] = io_jump && (io_jumpTarget < 16'd256) && (io_jumpTarget != 16'd0);
    hit[1] = io_dataAccess && (io_dataAddr < 16'd16);
    hit[2] = io_regRead && (io_regASel < 5'd4);
    hit[3] = io_regRead && (io_regBSel < 5'd4);
    hit[4] = io_regWriteEnable && (io_regWriteSel < 5'd4);
    hit[5] = (m_count >= 32'(TB_STEP - 1));
    for (int i = 0; i < 6; i++) if (hit[i]) return i + 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_started = 0; m_fault = 0; m_done = 0;
    m_count = 0; m_cause = 0; m_fpc = 0;
  endtask

  task automatic model_edge();
    int c;
    if (!m_started) begin
      if (io_run) m_started = 1;
    end else if (!m_fault && !m_done) begin
      c = (io_pc >= 16'd256) ? first_cause() : 0;
      if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
      if (c != 0) begin
        m_fault = 1; m_cause = 3'(c); m_fpc = io_pc;
      end else if (io_cpuDone) begin
        m_done = 1;
      end
    end
  endtask

  task automatic idle_inputs();
    io_run = 0; io_pc = 16'd300; io_jump = 0; io_jumpTarget = 0;
    io_dataAccess = 0; io_dataAddr = 16'd100; io_regRead = 0;
    io_regASel = 5'd10; io_regBSel = 5'd10; io_regWriteEnable = 0;
    io_regWriteSel = 5'd10; io_syscallReg = 0; io_cpuDone = 0;
  endtask

  task automatic check_comb();
    bit priv;
    priv = (io_pc < 16'd256);
    chk("privileged", 32'(io_privileged), 32'(priv));
    chk("prog_offset", 32'(io_programMemoryOffset),
        (priv || io_syscallReg != 0) ? 32'd0 : 32'd256);
    chk("data_offset", 32'(io_dataMemoryOffset), priv ? 32'd0 : 32'd256);
  endtask

  task automatic check_regs();
    chk("fault", 32'(io_fault), 32'(m_fault));
    chk("halt", 32'(io_halt), 32'(m_fault || m_done));
    chk("cause", 32'(io_faultCause), 32'(m_cause));
    chk("fault_pc", 32'(io_faultPc), 32'(m_fpc));
    chk("cycle_count", io_cycleCount, m_count);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_fault"}, 32'(io_fault), 32'd0);
    chk({tag, "_halt"}, 32'(io_halt), 32'd0);
    chk({tag, "_cause"}, 32'(io_faultCause), 32'd0);
    chk({tag, "_fpc"}, 32'(io_faultPc), 32'd0);
    chk({tag, "_count"}, io_cycleCount, 32'd0);
    chk({tag, "_prog_off"}, 32'(io_programMemoryOffset), 32'd0);
    chk({tag, "_data_off"}, 32'(io_dataMemoryOffset), 32'd0);
    chk({tag, "_priv"}, 32'(io_privileged), 32'(io_pc < 16'd256));
  endtask

  // called at a negedge with inputs already driven
  task automatic cycle();
    #1 check_comb();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_regs();
  endtask

  task automatic do_reset();
    reset = 0;
    idle_inputs();
    #1 check_all_zero("rst");
    model_reset();
    @(negedge clock);
    reset = 1;
  endtask

  task automatic rand_inputs();
    io_run            = ($urandom_range(0, 9) != 0);
    io_pc             = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 255))
                                                    : 16'($urandom_range(256, 65535));
    io_jump           = ($urandom_range(0, 9) == 0);
    case ($urandom_range(0, 2))
      0:       io_jumpTarget = 16'd0;
      1:       io_jumpTarget = 16'($urandom_range(0, 300));
      default: io_jumpTarget = 16'($urandom);
    endcase
    io_dataAccess     = ($urandom_range(0, 7) == 0);
    io_dataAddr       = 16'($urandom_range(0, 40));
    io_regRead        = ($urandom_range(0, 7) == 0);
    io_regASel        = 5'($urandom);
    io_regBSel        = 5'($urandom);
    io_regWriteEnable = ($urandom_range(0, 7) == 0);
    io_regWriteSel    = 5'($urandom);
    io_syscallReg     = ($urandom_range(0, 1) != 0) ? 32'd0 : $urandom;
    io_cpuDone        = ($urandom_range(0, 24) == 0);
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    model_reset();
    @(negedge clock);
    do_reset();

    // idle user run, offsets and syscall override
    io_run = 1; io_pc = 16'd300;
    repeat (11) cycle();
    chk("t1_count10", io_cycleCount, 32'd10);
    io_syscallReg = 5;
    cycle();
    io_syscallReg = 0; io_pc = 16'd10;
    cycle();

    // jump to entry is legal, other ring-0 targets fault
    do_reset();
    io_run = 1; io_pc = 16'd300;
    cycle();
    io_jump = 1; io_jumpTarget = 16'd0;
    cycle();
    io_jumpTarget = 16'd40;
    cycle();
    io_jump = 0;
    cycle();
    chk("t3_cause", 32'(io_faultCause), 32'd1);
    chk("t3_fpc", 32'(io_faultPc), 32'd300);

    // simultaneous violations, lowest code wins, first fault sticky
    do_reset();
    io_run = 1; io_pc = 16'd300;
    cycle();
    io_dataAccess = 1; io_dataAddr = 16'd15; io_regWriteEnable = 1; io_regWriteSel = 5'd2;
    cycle();
    io_dataAccess = 0; io_regWriteEnable = 0; io_regRead = 1; io_regASel = 5'd1;
    cycle();
    chk("t4_cause", 32'(io_faultCause), 32'd2);

    // boundary accesses are legal, then clean completion
    do_reset();
    io_run = 1; io_pc = 16'd300;
    cycle();
    io_dataAccess = 1; io_dataAddr = 16'd16; io_regRead = 1; io_regASel = 5'd4; io_regBSel = 5'd4;
    repeat (2) cycle();
    io_dataAccess = 0; io_regRead = 0; io_cpuDone = 1;
    cycle();
    io_cpuDone = 0;
    repeat (3) cycle();
    chk("t5_frozen", io_cycleCount, 32'd3);

    // fault and done on the same edge: fault wins
    do_reset();
    io_run = 1; io_pc = 16'd300;
    cycle();
    io_cpuDone = 1; io_regWriteEnable = 1; io_regWriteSel = 5'd3;
    cycle();
    chk("t5b_cause", 32'(io_faultCause), 32'd5);

    // watchdog, then asynchronous reset mid-fault
    do_reset();
    io_run = 1; io_pc = 16'd300;
    repeat (21) cycle();
    chk("t6_cause", 32'(io_faultCause), 32'd6);
    #2 reset = 0;
    #1 check_all_zero("t6_async");
    model_reset();
    @(negedge clock);
    check_all_zero("t6_held");
    reset = 1;
    idle_inputs();

    for (int seg = 0; seg < 40; seg++) begin
      do_reset();
      for (int k = 0; k < 35; k++) begin
        rand_inputs();
        cycle();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
